stack_ctrl: RTL

//   Sequencer for the SPReg stack-pointer register and a synchronous stack RAM.

---
 rtl/stack_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   Sequencer for an external stack-pointer register (SPReg) and a
//   synchronous stack RAM. Accepts push / pop / clear requests from the core.
//   It drives the SPReg ctrl code and the RAM address and write strobes. It
//   also tracks depth for full/empty and flags overflow and underflow. The
//   stack grows upward, and SP always points at the next free slot.
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_rst          asynchronous, active-high reset
//   i_push_req     push request (sampled only while o_busy=0)
//   i_push_data    push data, latched when a push is accepted
//   i_pop_req      pop request (sampled only while o_busy=0)
//   i_clr_req      empty-stack request (sampled only while o_busy=0)
//   o_busy         1 = requests are ignored this cycle
//   o_pop_data     last popped word, held until the next pop completes
//   o_pop_valid    one-cycle pulse: o_pop_data newly updated
//   o_full         depth count == DEPTH
//   o_empty        depth count == 0
//   o_err          one-cycle pulse: push when full / pop when empty
//   o_sp_ctrl      SPReg ctrl: 00 hold, 01 clear, 10 inc, 11 dec
//   i_sp           current SPReg value
//   o_mem_addr     RAM address
//   o_mem_we       RAM write enable
//   o_mem_wdata    RAM write data
//   i_mem_rdata    RAM read data, valid one cycle after o_mem_addr
//   o_dbg_state    current FSM state encoding
//
// Handshake: a request is taken on a rising edge where o_busy=0. Only one
// request is taken per acceptance, with priority clear > pop > push. A
// request seen while o_busy=1 is dropped, not queued, so requesters hold
// their request until they see o_busy=0.
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int DEPTH = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push_req,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop_req,
    input  logic         i_clr_req,
    output logic         o_busy,
    output logic [W-1:0] o_pop_data,
    output logic         o_pop_valid,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_err,
    output logic [1:0]   o_sp_ctrl,
    input  logic [N-1:0] i_sp,
    output logic [N-1:0] o_mem_addr,
    output logic         o_mem_we,
    output logic [W-1:0] o_mem_wdata,
    input  logic [W-1:0] i_mem_rdata,
    output logic [2:0]   o_dbg_state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_PUSH   = 3'd2,
        S_POPDEC = 3'd3,
        S_POPRD  = 3'd4,
        S_POPCAP = 3'd5,
        S_CLR    = 3'd6
    } state_t;

    localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);

    state_t       r_state;
    logic [N:0]   r_count;     // one bit wider than SP so DEPTH == 2**N fits
    logic [W-1:0] r_data;
    logic [W-1:0] r_pop_data;
    logic         r_pop_valid;
    logic         r_err;

    logic         w_full;
    logic         w_empty;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_count     <= '0;
            r_data      <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_INIT:   r_state <= S_IDLE;
                S_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= S_CLR;
                    end else if (i_pop_req) begin
                        // Underflow: flag it and leave SP and the RAM untouched
                        if (w_empty) r_err   <= 1'b1;
                        else         r_state <= S_POPDEC;
                    end else if (i_push_req) begin
                        // Overflow: flag it and leave SP and the RAM untouched
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_PUSH;
                            r_data  <= i_push_data;
                        end
                    end
                end
                S_PUSH: begin
                    r_count <= r_count + (N+1)'(1);
                    r_state <= S_IDLE;
                end
                S_POPDEC: begin
                    r_count <= r_count - (N+1)'(1);
                    r_state <= S_POPRD;
                end
                // SP already holds the decremented value here; the RAM answers next cycle
                S_POPRD:  r_state <= S_POPCAP;
                S_POPCAP: begin
                    r_pop_data  <= i_mem_rdata;
                    r_pop_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_CLR: begin
                    r_count <= '0;
                    r_state <= S_IDLE;
                end
                default:  r_state <= S_INIT;
            endcase
        end
    end

    // Strobes are decoded from state alone. An async reset forces S_INIT,
    // so mem_we drops at once without waiting for a clock.
    always_comb begin
        o_sp_ctrl  = 2'b00;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_busy     = 1'b1;
        case (r_state)
            S_INIT:   o_sp_ctrl = 2'b01;  // SPReg has no reset of its own
            S_IDLE:   o_busy    = 1'b0;
            S_PUSH: begin
                o_sp_ctrl  = 2'b10;
                o_mem_we   = 1'b1;
                o_mem_addr = i_sp;
            end
            S_POPDEC: o_sp_ctrl  = 2'b11;
            S_POPRD:  o_mem_addr = i_sp;
            S_CLR:    o_sp_ctrl  = 2'b01;
            default:  o_sp_ctrl  = 2'b00;
        endcase
    end

    assign o_mem_wdata = r_data;
    assign o_pop_data  = r_pop_data;
    assign o_pop_valid = r_pop_valid;
    assign o_err       = r_err;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_dbg_state = r_state;

endmodule
